pwm_compare: RTL and testbench

- Downstream consumer of the parameterised free-running up-counter.
- Takes the counter's count value and compares it against a double-buffered duty value to produce a registered PWM output and a one-cycle period tick on every counter wrap.
- New duty values arrive over a valid/ready handshake and are applied only at period boundaries, so pwm_out never glitches mid-period.

---
 rtl/pwm_compare.sv | 93 +++++++++
 tb/tb_pwm_compare.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_compare.sv
// PWM comparator fed by an upstream free-running counter; 1-cycle latency from count_in to pwm_out.
// Duty updates use valid/ready and are applied only at a wrap. Optional wrap counter under PWM_PERIOD_CNT_EN.
module pwm_compare #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count_in,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             period_tick,
    output logic [WIDTH-1:0] active_duty
`ifdef PWM_PERIOD_CNT_EN
    ,
    output logic [CNT_W-1:0] period_cnt
`endif
);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
        $error("pwm_compare: WIDTH and CNT_W must be at least 1");
    end

    state_t           state_q;
    logic [WIDTH-1:0] prev_count_q;
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] active_duty_q;
    logic             pwm_q;
    logic             tick_q;
    logic             wrap_d;
    logic             pwm_d;

    // Any drop in count is a period boundary, including an upstream counter reset.
    assign wrap_d = (count_in < prev_count_q);
    assign pwm_d  = (count_in < active_duty_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            prev_count_q  <= '0;
            shadow_q      <= '0;
            active_duty_q <= '0;
            pwm_q         <= 1'b0;
            tick_q        <= 1'b0;
        end else begin
            prev_count_q <= count_in;
            tick_q       <= wrap_d;
            pwm_q        <= pwm_d;
            case (state_q)
                IDLE: begin
                    if (duty_valid) begin
                        shadow_q <= duty_in;
                        state_q  <= PENDING;
                    end
                end
                PENDING: begin
                    if (wrap_d) begin
                        active_duty_q <= shadow_q;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign duty_ready  = (state_q == IDLE);
    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;
    assign active_duty = active_duty_q;

`ifdef PWM_PERIOD_CNT_EN
    logic [CNT_W-1:0] period_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt_q <= '0;
        end else if (wrap_d) begin
            period_cnt_q <= period_cnt_q + CNT_W'(1);
        end
    end

    assign period_cnt = period_cnt_q;
`endif

endmodule

// File: tb/tb_pwm_compare.sv
// Randomized and directed bench for pwm_compare against a queue-based reference model.
module tb_pwm_compare;
    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] count_in = '0;
    logic [WIDTH-1:0] duty_in = '0;
    logic             duty_valid = 1'b0;
    logic             duty_ready;
    logic             pwm_out;
    logic             period_tick;
    logic [WIDTH-1:0] active_duty;
`ifdef PWM_PERIOD_CNT_EN
    logic [CNT_W-1:0] period_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: accepted duties sit in a queue until the next boundary.
    logic [WIDTH-1:0] m_prev;
    logic [WIDTH-1:0] m_active;
    logic [WIDTH-1:0] m_q[$];
    bit               m_pwm;
    bit               m_tick;
    int               m_pcnt;

    pwm_compare #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .count_in   (count_in),
        .duty_in    (duty_in),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .pwm_out    (pwm_out),
        .period_tick(period_tick),
        .active_duty(active_duty)
`ifdef PWM_PERIOD_CNT_EN
        ,
        .period_cnt (period_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_prev = '0; m_active = '0; m_q.delete();
        m_pwm = 0; m_tick = 0; m_pcnt = 0;
    endtask

    task automatic model_edge();
        bit wrap;
        wrap   = (int'(count_in) < int'(m_prev));
        m_pwm  = (int'(count_in) < int'(m_active));
        m_tick = wrap;
        if (wrap) m_pcnt = (m_pcnt + 1) % (1 << CNT_W);
        if (m_q.size() != 0) begin
            if (wrap) m_active = m_q.pop_front();
        end else if (duty_valid) begin
            m_q.push_back(duty_in);
        end
        m_prev = count_in;
    endtask

    // One clock: model sees the inputs present at the edge, then the counter advances.
    task automatic step();
        @(posedge clk);
        if (rst) model_reset(); else model_edge();
        #1;
        count_in = count_in + 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; count_in = '0; duty_valid = 1'b0;
        model_reset();
        repeat (3) step();
        checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm got %b exp 0", pwm_out); end
        checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", period_tick); end
        checks++; if (active_duty !== 4'd0) begin errors++; $display("FAIL reset_active got %0d exp 0", active_duty); end
        checks++; if (duty_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", duty_ready); end
`ifdef PWM_PERIOD_CNT_EN
        checks++; if (period_cnt !== 8'd0) begin errors++; $display("FAIL reset_pcnt got %0d exp 0", period_cnt); end
`endif
        rst = 1'b0; count_in = '0;
        step();
        checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL first_tick got %b exp 0", period_tick); end
    endtask

    task automatic test_basic();
        int highs, ticks;
        while (count_in != 4'd7) step();
        duty_in = 4'd4; duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        checks++; if (duty_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_fall got %b exp 0", duty_ready); end
        while (count_in != 4'd0) begin
            step();
            checks++; if (active_duty !== 4'd0) begin errors++; $display("FAIL basic_early got %0d exp 0", active_duty); end
        end
        step();
        checks++; if (active_duty !== 4'd4) begin errors++; $display("FAIL basic_active got %0d exp 4", active_duty); end
        checks++; if (duty_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_rise got %b exp 1", duty_ready); end
        checks++; if (period_tick !== 1'b1) begin errors++; $display("FAIL basic_tick got %b exp 1", period_tick); end
        highs = 0; ticks = 0;
        repeat (16) begin
            step();
            highs += int'(pwm_out);
            ticks += int'(period_tick);
        end
        checks++; if (highs != 4) begin errors++; $display("FAIL basic_highs got %0d exp 4", highs); end
        checks++; if (ticks != 1) begin errors++; $display("FAIL basic_ticks got %0d exp 1", ticks); end
    endtask

    task automatic test_back_to_back();
        int n;
        duty_in = 4'd4; duty_valid = 1'b1;
        step();
        duty_in = 4'd9;
        checks++; if (duty_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b exp 0", duty_ready); end
        n = 0;
        while (duty_ready !== 1'b1 && n < 40) begin step(); n++; end
        checks++; if (n != 15) begin errors++; $display("FAIL bp_wait got %0d exp 15", n); end
        checks++; if (active_duty !== 4'd4) begin errors++; $display("FAIL bp_active4 got %0d exp 4", active_duty); end
        step();
        duty_valid = 1'b0;
        checks++; if (duty_ready !== 1'b0) begin errors++; $display("FAIL bp_accept got %b exp 0", duty_ready); end
        n = 1;
        while (active_duty !== 4'd9 && n < 40) begin step(); n++; end
        checks++; if (n != 16) begin errors++; $display("FAIL bp_apply9 got %0d exp 16", n); end
    endtask

    task automatic test_extremes();
        int n, cnt;
        duty_in = 4'd0; duty_valid = 1'b1; step(); duty_valid = 1'b0;
        n = 0;
        while (active_duty !== 4'd0 && n < 40) begin step(); n++; end
        checks++; if (n >= 40) begin errors++; $display("FAIL ext0_timeout got %0d exp <40", n); end
        cnt = 0;
        repeat (32) begin step(); cnt += int'(pwm_out); end
        checks++; if (cnt != 0) begin errors++; $display("FAIL ext0_highs got %0d exp 0", cnt); end
        duty_in = 4'd15; duty_valid = 1'b1; step(); duty_valid = 1'b0;
        n = 0;
        while (active_duty !== 4'd15 && n < 40) begin step(); n++; end
        checks++; if (n >= 40) begin errors++; $display("FAIL ext15_timeout got %0d exp <40", n); end
        cnt = 0;
        repeat (16) begin step(); cnt += int'(!pwm_out); end
        checks++; if (cnt != 1) begin errors++; $display("FAIL ext15_lows got %0d exp 1", cnt); end
    endtask

    task automatic test_upstream_reset();
        int pc0;
        while (count_in != 4'd2) step();
        duty_in = 4'd6; duty_valid = 1'b1; step(); duty_valid = 1'b0;
        while (count_in != 4'd10) step();
        checks++; if (duty_ready !== 1'b0) begin errors++; $display("FAIL ups_pending got %b exp 0", duty_ready); end
        step();
        count_in = 4'd0;
        pc0 = m_pcnt;
        step();
        checks++; if (period_tick !== 1'b1) begin errors++; $display("FAIL ups_tick got %b exp 1", period_tick); end
        checks++; if (active_duty !== 4'd6) begin errors++; $display("FAIL ups_active got %0d exp 6", active_duty); end
        checks++; if (duty_ready !== 1'b1) begin errors++; $display("FAIL ups_ready got %b exp 1", duty_ready); end
`ifdef PWM_PERIOD_CNT_EN
        checks++; if (int'(period_cnt) != (pc0 + 1) % 256) begin errors++; $display("FAIL ups_pcnt got %0d exp %0d", period_cnt, (pc0 + 1) % 256); end
`endif
        step();
        checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL ups_single got %b exp 0", period_tick); end
    endtask

    task automatic test_rst_mid_pending();
        while (count_in != 4'd3) step();
        duty_in = 4'd12; duty_valid = 1'b1; step(); duty_valid = 1'b0;
        checks++; if (duty_ready !== 1'b0) begin errors++; $display("FAIL rstp_pending got %b exp 0", duty_ready); end
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        checks++; if (active_duty !== 4'd0) begin errors++; $display("FAIL rstp_active got %0d exp 0", active_duty); end
        checks++; if (duty_ready !== 1'b1) begin errors++; $display("FAIL rstp_ready got %b exp 1", duty_ready); end
        checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL rstp_pwm got %b exp 0", pwm_out); end
`ifdef PWM_PERIOD_CNT_EN
        checks++; if (period_cnt !== 8'd0) begin errors++; $display("FAIL rstp_pcnt got %0d exp 0", period_cnt); end
`endif
        step();
        rst = 1'b0; count_in = 4'd0;
        repeat (40) begin
            step();
            checks++; if (active_duty !== 4'd0 || duty_ready !== 1'b1) begin
                errors++; $display("FAIL rstp_after got active=%0d ready=%b exp 0/1", active_duty, duty_ready);
            end
        end
    endtask

    task automatic test_random();
        bit accepted;
        for (int i = 0; i < 2000; i++) begin
            accepted = duty_valid && (m_q.size() == 0);
            step();
            if ($urandom_range(0, 19) == 0) count_in = WIDTH'($urandom_range(0, 15));
            if (!duty_valid || accepted) begin
                duty_valid = ($urandom_range(0, 3) == 0);
                duty_in    = WIDTH'($urandom_range(0, 15));
            end
            checks++; if (pwm_out !== m_pwm) begin errors++; $display("FAIL rnd_pwm cyc %0d got %b exp %b", i, pwm_out, m_pwm); end
            checks++; if (period_tick !== m_tick) begin errors++; $display("FAIL rnd_tick cyc %0d got %b exp %b", i, period_tick, m_tick); end
            checks++; if (active_duty !== m_active) begin errors++; $display("FAIL rnd_active cyc %0d got %0d exp %0d", i, active_duty, m_active); end
            checks++; if (duty_ready !== (m_q.size() == 0)) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", i, duty_ready, m_q.size() == 0); end
`ifdef PWM_PERIOD_CNT_EN
            checks++; if (int'(period_cnt) != m_pcnt) begin errors++; $display("FAIL rnd_pcnt cyc %0d got %0d exp %0d", i, period_cnt, m_pcnt); end
`endif
        end
        duty_valid = 1'b0;
    endtask

`ifdef PWM_PERIOD_CNT_EN
    task automatic test_period_wrap();
        int start;
        int last;
        bit seen;
        start = m_pcnt;
        last  = int'(period_cnt);
        seen  = 0;
        repeat (256 * 16) begin
            step();
            if (last == 255 && period_cnt == 8'd0) seen = 1;
            last = int'(period_cnt);
        end
        checks++; if (!seen) begin errors++; $display("FAIL pcnt_wrap got no 255->0 exp one"); end
        checks++; if (int'(period_cnt) != start) begin errors++; $display("FAIL pcnt_full got %0d exp %0d", period_cnt, start); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_extremes();
        test_upstream_reset();
        test_rst_mid_pending();
        test_random();
`ifdef PWM_PERIOD_CNT_EN
        test_period_wrap();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
